// File: rtl/result_writeback_ctrl.sv
// result_writeback_ctrl
//   Snapshots the systolic array's C result matrix on a single-cycle strobe,
//   narrows each 2*DATA_WIDTH element to DATA_WIDTH (saturating or truncating),
//   then streams the elements to row-major result memory over a valid/ready
//   write handshake.  The array may start its next computation as soon as the
//   snapshot has been taken.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   result_valid  strobe: result is valid this cycle
//   result        unpacked [A_ROWS][B_COLS] matrix of 2*DATA_WIDTH elements
//   ready         controller idle and able to accept result_valid
//   wr_valid      memory write request
//   wr_addr       write address (BASE_ADDR + row-major element index)
//   wr_data       converted element
//   wr_ready      memory accepts the write when wr_valid && wr_ready
//   busy          write sequence in progress (WRITE or DONE)
//   done          one-cycle pulse after the last element is accepted
//   overrun       one-cycle pulse: a strobe arrived while not ready and was dropped
module result_writeback_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned A_ROWS     = 2,
  parameter int unsigned B_COLS     = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned SATURATE   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    result_valid,
  input  logic [2*DATA_WIDTH-1:0] result [0:A_ROWS-1][0:B_COLS-1],
  output logic                    ready,
  output logic                    wr_valid,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int unsigned NUM   = A_ROWS * B_COLS;
  localparam int unsigned IW    = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned DEPTH = 1 << IW;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shadow [0:DEPTH-1];
  logic                  capture;
  logic                  last;

  // Elements are converted on capture, so the shadow only holds DATA_WIDTH
  // bits and the write path is a plain array read.
  function automatic logic [DATA_WIDTH-1:0] conv(input logic [2*DATA_WIDTH-1:0] x);
    if ((SATURATE != 0) && (|x[2*DATA_WIDTH-1:DATA_WIDTH]))
      conv = '1;
    else
      conv = x[DATA_WIDTH-1:0];
  endfunction

  assign last = (idx == IW'(NUM - 1));

  // The shadow is flattened row-major, so the linear index addresses both the
  // shadow entry and the memory word without any divide/modulo.
  assign wr_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx);
  assign wr_data = (state == WRITE) ? shadow[idx] : '0;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    wr_valid  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (result_valid) begin
          capture   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        wr_valid = 1'b1;
        busy     = 1'b1;
        if (wr_ready && last)
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      overrun <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++)
        shadow[k] <= '0;
    end else begin
      state   <= state_nxt;
      overrun <= result_valid && (state != IDLE);
      if (capture) begin
        idx <= '0;
        for (int unsigned r = 0; r < A_ROWS; r++)
          for (int unsigned c = 0; c < B_COLS; c++)
            shadow[IW'(r * B_COLS + c)] <= conv(result[r][c]);
      end
      // Index returns to 0 after the last accept so wr_addr idles at BASE_ADDR.
      if ((state == WRITE) && wr_ready)
        idx <= last ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_result_writeback_ctrl.sv
// Bench for result_writeback_ctrl: two instances (2x2 saturating at base 0,
// 3x2 truncating at base 0x10) share control inputs and are compared every
// cycle against a queue-of-expected-writes reference model.
module tb_result_writeback_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, result_valid, wr_ready;
  logic [15:0] res_a [0:1][0:1];
  logic [15:0] res_b [0:2][0:1];
  logic [15:0] nxt_a [0:1][0:1];
  logic [15:0] nxt_b [0:2][0:1];

  logic       a_ready, a_wr_valid, a_busy, a_done, a_overrun;
  logic [7:0] a_wr_addr, a_wr_data;
  logic       b_ready, b_wr_valid, b_busy, b_done, b_overrun;
  logic [7:0] b_wr_addr, b_wr_data;

  result_writeback_ctrl #(
    .DATA_WIDTH(8), .A_ROWS(2), .B_COLS(2), .ADDR_WIDTH(8),
    .BASE_ADDR(0), .SATURATE(1)
  ) u_a (
    .clk(clk), .reset(reset), .result_valid(result_valid), .result(res_a),
    .ready(a_ready), .wr_valid(a_wr_valid), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_ready(wr_ready), .busy(a_busy),
    .done(a_done), .overrun(a_overrun)
  );

  result_writeback_ctrl #(
    .DATA_WIDTH(8), .A_ROWS(3), .B_COLS(2), .ADDR_WIDTH(8),
    .BASE_ADDR(16), .SATURATE(0)
  ) u_b (
    .clk(clk), .reset(reset), .result_valid(result_valid), .result(res_b),
    .ready(b_ready), .wr_valid(b_wr_valid), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_ready(wr_ready), .busy(b_busy),
    .done(b_done), .overrun(b_overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 writing, 2 done-pulse cycle.
  int          m_phase [2];
  bit          m_ov    [2];
  int          m_pos   [2];
  int          m_len   [2];
  int unsigned exp_addr [2][0:5];
  int unsigned exp_data [2][0:5];

  function automatic int unsigned conv(input int unsigned x, input bit sat);
    if (sat) return (x > 255) ? 255 : x;
    return x % 256;
  endfunction

  task automatic fill(input int d);
    int rows;
    int unsigned base, v;
    bit sat;
    rows = (d == 0) ? 2 : 3;
    base = (d == 0) ? 0 : 16;
    sat  = (d == 0);
    for (int i = 0; i < rows; i++)
      for (int j = 0; j < 2; j++) begin
        v = (d == 0) ? int'(res_a[i][j]) : int'(res_b[i][j]);
        exp_addr[d][i*2+j] = base + i*2 + j;
        exp_data[d][i*2+j] = conv(v, sat);
      end
    m_len[d] = rows * 2;
    m_pos[d] = 0;
  endtask

  task automatic advance(input int d);
    if (reset) begin
      m_phase[d] = 0;
      m_ov[d]    = 1'b0;
    end else begin
      m_ov[d] = result_valid && (m_phase[d] != 0);
      if (m_phase[d] == 0) begin
        if (result_valid) begin
          fill(d);
          m_phase[d] = 1;
        end
      end else if (m_phase[d] == 1) begin
        if (wr_ready) begin
          m_pos[d]++;
          if (m_pos[d] == m_len[d]) m_phase[d] = 2;
        end
      end else begin
        m_phase[d] = 0;
      end
    end
  endtask

  task automatic check_dut(input int d);
    string p;
    logic rdy, wv, bz, dn, ov;
    logic [7:0] wa, wd;
    if (d == 0) begin
      p = "a"; rdy = a_ready; wv = a_wr_valid; bz = a_busy; dn = a_done;
      ov = a_overrun; wa = a_wr_addr; wd = a_wr_data;
    end else begin
      p = "b"; rdy = b_ready; wv = b_wr_valid; bz = b_busy; dn = b_done;
      ov = b_overrun; wa = b_wr_addr; wd = b_wr_data;
    end
    check({p, " ready"},    rdy, m_phase[d] == 0);
    check({p, " busy"},     bz,  m_phase[d] != 0);
    check({p, " done"},     dn,  m_phase[d] == 2);
    check({p, " wr_valid"}, wv,  m_phase[d] == 1);
    check({p, " overrun"},  ov,  m_ov[d]);
    if (m_phase[d] == 1) begin
      check({p, " wr_addr"}, wa, exp_addr[d][m_pos[d]]);
      check({p, " wr_data"}, wd, exp_data[d][m_pos[d]]);
    end
  endtask

  // One cycle: check outputs of the previous edge, then apply new inputs
  // (sampled at the coming edge) and advance the model to match.
  task automatic step(input logic r, input logic rv, input logic wr);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    reset        = r;
    result_valid = rv;
    wr_ready     = wr;
    res_a        = nxt_a;
    res_b        = nxt_b;
    advance(0);
    advance(1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [15:0] rnd16();
    if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 255));
    return 16'($urandom_range(0, 65535));
  endfunction

  task automatic randomize_next();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) nxt_a[i][j] = rnd16();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++) nxt_b[i][j] = rnd16();
  endtask

  initial begin
    reset = 1'b1; result_valid = 1'b0; wr_ready = 1'b1;
    nxt_a = '{'{16'd0, 16'd0}, '{16'd0, 16'd0}};
    nxt_b = '{'{16'd0, 16'd0}, '{16'd0, 16'd0}, '{16'd0, 16'd0}};
    res_a = nxt_a;
    res_b = nxt_b;
    // Strobe during reset must capture nothing.
    result_valid = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_ov[d] = 1'b0; m_pos[d] = 0; m_len[d] = 0;
    end
    @(posedge clk);
    #1;
    check("reset a wr_addr", a_wr_addr, 0);
    check("reset a wr_data", a_wr_data, 0);
    check("reset b wr_addr", b_wr_addr, 16);
    check("reset b wr_data", b_wr_data, 0);
    step(1'b1, 1'b0, 1'b1);
    run(8);

    // Basic transfer.
    nxt_a = '{'{16'd3, 16'd5}, '{16'd7, 16'd9}};
    nxt_b = '{'{16'd1, 16'd2}, '{16'd3, 16'd4}, '{16'd5, 16'd6}};
    step(1'b0, 1'b1, 1'b1);
    run(9);

    // Saturation / truncation boundaries.
    nxt_a = '{'{16'd255, 16'd256}, '{16'h1234, 16'd0}};
    nxt_b = '{'{16'd255, 16'd256}, '{16'h1234, 16'd0}, '{16'hffff, 16'h01ff}};
    step(1'b0, 1'b1, 1'b1);
    run(9);

    // Backpressure during element 1.
    nxt_a = '{'{16'd10, 16'd20}, '{16'd30, 16'd40}};
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run(10);

    // Overrun while writing, with the source matrix changed after capture.
    nxt_a = '{'{16'd11, 16'd12}, '{16'd13, 16'd14}};
    nxt_b = '{'{16'd21, 16'd22}, '{16'd23, 16'd24}, '{16'd25, 16'd26}};
    step(1'b0, 1'b1, 1'b1);
    nxt_a = '{'{16'd99, 16'd98}, '{16'd97, 16'd96}};
    nxt_b = '{'{16'd91, 16'd92}, '{16'd93, 16'd94}, '{16'd95, 16'd90}};
    step(1'b0, 1'b1, 1'b1);
    run(9);

    // Reset after two writes, then a fresh start from BASE_ADDR.
    nxt_a = '{'{16'd1, 16'd300}, '{16'd4, 16'd8}};
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    run(3);
    nxt_a = '{'{16'd42, 16'd43}, '{16'd44, 16'd45}};
    step(1'b0, 1'b1, 1'b1);
    run(9);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      randomize_next();
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) != 0));
    end
    run(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
